// File: rtl/mrge_pkg.sv
// ---------------------------------------------------------------------------
// mrge_pkg
// Shared constants for the merge-sorter output serializer.
//   MRGE_W : data word width
//   MRGE_N : words per sorted frame
//   SLOTS  : number of frame buffers (double buffering)
//   IDX_W  : width of the word index within a frame
// ---------------------------------------------------------------------------
package mrge_pkg;

    localparam int MRGE_W = 16;
    localparam int MRGE_N = 5;
    localparam int SLOTS  = 2;
    localparam int IDX_W  = 3;

endpackage : mrge_pkg

// File: rtl/mrge_order_chk.sv
// ---------------------------------------------------------------------------
// mrge_order_chk
// Combinational checker: flags a frame that is not non-decreasing.
// Equal neighbours are legal; compare is unsigned.
// Ports:
//   d   : N words, d[0] expected smallest
//   bad : 1 when any d[i] > d[i+1]
// ---------------------------------------------------------------------------
module mrge_order_chk
    import mrge_pkg::*;
#(
    parameter int W = MRGE_W,
    parameter int N = MRGE_N
) (
    input  logic [W-1:0] d [N],
    output logic         bad
);

    logic [N-2:0] pair_bad;

    for (genvar gi = 0; gi < N - 1; gi++) begin : g_pair
        assign pair_bad[gi] = (d[gi] > d[gi+1]);
    end

    assign bad = |pair_bad;

endmodule : mrge_order_chk

// File: rtl/mrge_serializer.sv
// ---------------------------------------------------------------------------
// mrge_serializer
// Double-buffered serializer: captures a sorted 5-word frame in one cycle and
// streams it out one word per accepted beat, with an order-error flag per frame.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_load           : frame strobe (accepted when in_ready)
//   in_d1..in_d5      : frame words, in_d1 = smallest
//   in_ready          : a frame slot is free
//   out_data/out_valid/out_ready : serial stream handshake
//   out_idx, out_last : word position within the frame, final-word marker
//   order_err         : current frame was not non-decreasing at load
//   ovf               : sticky, a load was dropped because both slots were full
// ---------------------------------------------------------------------------
module mrge_serializer
    import mrge_pkg::*;
#(
    parameter int W = MRGE_W,
    parameter int N = MRGE_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_load,
    input  logic [W-1:0]     in_d1,
    input  logic [W-1:0]     in_d2,
    input  logic [W-1:0]     in_d3,
    input  logic [W-1:0]     in_d4,
    input  logic [W-1:0]     in_d5,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             order_err,
    output logic             ovf
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [1:0]       FULL_CNT = 2'(SLOTS);

    logic [W-1:0]     slot_data_q [SLOTS][N];
    logic [W-1:0]     slot_data_d [SLOTS][N];
    logic [SLOTS-1:0] slot_err_q, slot_err_d;
    logic             wp_q, wp_d;
    logic             rp_q, rp_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     in_frame [N];
    logic             load_bad;
    logic             load_acc;
    logic             beat;
    logic             last_beat;

    assign in_frame[0] = in_d1;
    assign in_frame[1] = in_d2;
    assign in_frame[2] = in_d3;
    assign in_frame[3] = in_d4;
    assign in_frame[4] = in_d5;

    mrge_order_chk #(
        .W (W),
        .N (N)
    ) u_order_chk (
        .d   (in_frame),
        .bad (load_bad)
    );

    // Output decode: everything comes from registered state, so in_ready has
    // no combinational dependence on out_ready.
    assign in_ready  = (cnt_q < FULL_CNT);
    assign out_valid = (cnt_q != 2'd0);
    assign out_idx   = idx_q;
    assign out_last  = out_valid & (idx_q == LAST_IDX);
    assign out_data  = out_valid ? slot_data_q[rp_q][idx_q] : '0;
    assign order_err = out_valid & slot_err_q[rp_q];
    assign ovf       = ovf_q;

    assign load_acc  = in_load & in_ready;
    assign beat      = out_valid & out_ready;
    assign last_beat = beat & out_last;

    always_comb begin
        slot_data_d = slot_data_q;
        slot_err_d  = slot_err_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q | (in_load & ~in_ready);

        if (load_acc) begin
            slot_data_d[wp_q] = in_frame;
            slot_err_d[wp_q]  = load_bad;
            wp_d              = ~wp_q;
        end

        if (beat) begin
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
                rp_d  = ~rp_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // A load and a final beat in the same cycle cancel in the occupancy.
        case ({load_acc, last_beat})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SLOTS; s++) begin
                for (int k = 0; k < N; k++) begin
                    slot_data_q[s][k] <= '0;
                end
            end
            slot_err_q <= '0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            cnt_q      <= 2'd0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            slot_data_q <= slot_data_d;
            slot_err_q  <= slot_err_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule : mrge_serializer

// File: tb/tb_mrge_serializer.sv
// ---------------------------------------------------------------------------
// tb_mrge_serializer
// Directed bench with a scoreboard: every accepted frame pushes its five
// expected beats; a negedge monitor pops and compares on each handshake.
// ---------------------------------------------------------------------------
module tb_mrge_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_load = 1'b0;
    logic [15:0] in_d1 = '0, in_d2 = '0, in_d3 = '0, in_d4 = '0, in_d5 = '0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        order_err;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  idx;
        logic        last;
        logic        err;
    } exp_t;

    exp_t sb[$];

    mrge_serializer #(.W(16), .N(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_load   (in_load),
        .in_d1     (in_d1),
        .in_d2     (in_d2),
        .in_d3     (in_d3),
        .in_d4     (in_d4),
        .in_d5     (in_d5),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .order_err (order_err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one frame for one clock edge; expected beats are queued only when
    // the bench expects the frame to be accepted.
    task automatic load_frame(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input logic [15:0] e, input bit accept);
        logic [15:0] w [5];
        logic        bad;
        exp_t        x;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e;
        bad = !((a <= b) && (b <= c) && (c <= d) && (d <= e));
        in_d1 = a; in_d2 = b; in_d3 = c; in_d4 = d; in_d5 = e;
        in_load = 1'b1;
        if (accept) begin
            for (int i = 0; i < 5; i++) begin
                x.d = w[i]; x.idx = 3'(i); x.last = (i == 4); x.err = bad;
                sb.push_back(x);
            end
        end
        $display("load %0d %0d %0d %0d %0d accept=%0b", a, b, c, d, e, accept);
        @(posedge clk);
        #1;
        in_load = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard monitor, sampled away from the rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = sb.pop_front();
                $display("beat data=%0d idx=%0d last=%0b err=%0b exp_data=%0d",
                         out_data, out_idx, out_last, order_err, x.d);
                chk("beat_data", 32'(out_data), 32'(x.d));
                chk("beat_idx",  32'(out_idx),  32'(x.idx));
                chk("beat_last", 32'(out_last), 32'(x.last));
                chk("beat_err",  32'(order_err), 32'(x.err));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_order_err", 32'(order_err), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Sorted frame, free-running sink; word 0 visible right after load
        out_ready = 1'b1;
        load_frame(16'd6, 16'd16, 16'd26, 16'd35, 16'd46, 1'b1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_idx",   32'(out_idx),   32'd0);
        chk("lat_data",  32'(out_data),  32'd6);
        drain("drain_sorted");
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Unsorted frame: order_err on every beat
        load_frame(16'd26, 16'd16, 16'd35, 16'd6, 16'd46, 1'b1);
        drain("drain_unsorted");

        // Back-pressure at idx 2
        out_ready = 1'b0;
        load_frame(16'd6, 16'd16, 16'd26, 16'd35, 16'd46, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_data", 32'(out_data), 32'd26);
            chk("stall_idx",  32'(out_idx),  32'd2);
            chk("stall_last", 32'(out_last), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain("drain_stall");

        // Fill both slots, drop a third frame, then stream 10 beats gap-free
        out_ready = 1'b0;
        load_frame(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 1'b1);
        chk("one_slot_ready", 32'(in_ready), 32'd1);
        load_frame(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 1'b1);
        chk("full_ready", 32'(in_ready), 32'd0);
        load_frame(16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_bubble_left", 32'(sb.size()), 32'd0);
        chk("no_bubble_idle", 32'(out_valid), 32'd0);
        chk("ovf_sticky",     32'(ovf),       32'd1);

        // Load coinciding with the final beat of the only buffered frame
        load_frame(16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_last_idx",   32'(out_idx),  32'd4);
        chk("pre_last_ready", 32'(in_ready), 32'd1);
        load_frame(16'd1, 16'd2, 16'd3, 16'd3, 16'd9, 1'b1);
        chk("overlap_valid", 32'(out_valid), 32'd1);
        chk("overlap_idx",   32'(out_idx),   32'd0);
        chk("overlap_data",  32'(out_data),  32'd1);
        chk("overlap_ready", 32'(in_ready),  32'd1);
        drain("drain_overlap");

        // Asynchronous reset mid-frame at idx 3
        load_frame(16'd11, 16'd22, 16'd33, 16'd44, 16'd55, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_idx", 32'(out_idx), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ovf",   32'(ovf),       32'd0);
        chk("arst_data",  32'(out_data),  32'd0);
        chk("arst_ready", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_frame(16'd3, 16'd5, 16'd5, 16'd8, 16'd13, 1'b1);
        chk("post_rst_idx", 32'(out_idx), 32'd0);
        drain("drain_post_rst");

        repeat (3) @(posedge clk);
        #1;
        chk("final_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mrge_serializer

// File: doc/mrge_serializer.md
MRGE_SERIALIZER -- requirements
Module: mrge_serializer

Interface
REQ-001 SHALL have parameters, one per line:
 - W, 16, data word width.
 - N, 5, words per sorted frame.
REQ-002 SHALL have ports, one per line:
 - clk  in  1  single clock, all state on rising edge.
 - rst  in  1  asynchronous, active-high reset.
 - in_load  in  1  frame strobe from the 5-input merge sorter; frame accepted when in_load & in_ready.
 - in_d1..in_d5  in  W each  sorted frame from the sorter outputs o1..o5, in_d1 = smallest.
 - in_ready  out  1  at least one frame slot free.
 - out_data  out  W  current serial word.
 - out_valid  out  1  out_data valid.
 - out_ready  in  1  downstream accepts the beat.
 - out_idx  out  3  index 0..N-1 of the current word within its frame.
 - out_last  out  1  current beat is word N-1.
 - order_err  out  1  current frame was not non-decreasing at load.
 - ovf  out  1  sticky; a load arrived while in_ready=0.
REQ-003 SHALL have one clock and an asynchronous active-high reset, named clk and rst.

Function
REQ-004 SHALL hold two frame slots, each N×W data plus a 1-bit order flag, with write pointer wp, read pointer rp and occupancy cnt (0..2).
REQ-005 in_ready SHALL equal (cnt<2), decoded from registered state only, with no combinational path from out_ready.
REQ-006 on in_load & in_ready, SHALL capture in_d1..in_d5 into slot wp, toggle wp and increment cnt.
REQ-007 SHALL compute the order flag at load as NOT(d1<=d2<=d3<=d4<=d5), unsigned compare; equal words are legal.
REQ-008 on in_load & ~in_ready, SHALL drop the frame, leave state unchanged and set ovf=1 until reset.
REQ-009 out_valid SHALL equal (cnt>0); out_data SHALL be slot rp, word out_idx; order_err SHALL be the slot rp flag, gated by out_valid.
REQ-010 latency: a frame loaded into an empty block SHALL present word 0 with out_valid=1 in the cycle after the load edge.
REQ-011 on out_valid & out_ready with out_idx<N-1, SHALL increment out_idx.
REQ-012 out_last SHALL equal out_valid & (out_idx==N-1).
REQ-013 on a beat with out_last=1, SHALL reset out_idx to 0, toggle rp and decrement cnt, freeing the slot.
REQ-014 with out_valid=1 & out_ready=0, SHALL hold out_data, out_idx, out_last and order_err stable.
REQ-015 simultaneous accepted load and final beat SHALL leave cnt unchanged, with both pointers toggled.
REQ-016 back-to-back frames SHALL stream without a bubble: word N-1 of frame A is followed by word 0 of frame B in the next cycle.

Reset
REQ-017 rst=1 SHALL force, asynchronously: cnt=0, wp=0, rp=0, out_idx=0, ovf=0. Outputs SHALL then read in_ready=1, out_valid=0, out_last=0, order_err=0, out_data=0.
REQ-018 rst asserted mid-frame SHALL discard all buffered frames with no partial completion; operation resumes on the first clk edge after release.
REQ-019 slot data registers SHALL also clear to 0 on reset.

Structure
REQ-020 shared package mrge_pkg SHALL hold W, N, the slot count (2) and the index width.
REQ-021 SHALL instantiate one sub-module, mrge_order_chk: combinational N-word non-decreasing checker producing the order flag.
REQ-022 SHALL be implemented as a single synchronous process plus combinational output decode; no latches and no gated clocks.

Verification
REQ-023 load {6,16,26,35,46}, out_ready=1 -> out_data 6,16,26,35,46 on cycles 1..5, out_idx 0..4, out_last only on cycle 5, order_err=0.
REQ-024 load {26,16,35,6,46} -> five beats 26,16,35,6,46, with order_err=1 on every beat.
REQ-025 load frame, hold out_ready=0 for 3 cycles at idx 2 -> out_data=26 stable, then resume to finish 35,46.
REQ-026 out_ready=0, load frame A then B, then a third load -> in_ready=0 after B, third frame dropped, ovf=1; release -> A then B stream without a gap (10 beats).
REQ-027 cnt=1, load a new frame in the same cycle as A's final beat -> cnt stays 1 and frame B word 0 appears the next cycle.
REQ-028 assert rst at idx 3 of a frame -> out_valid=0 and ovf=0 immediately; a new load after release streams from idx 0.
